// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with a
// single-request lookup port and a fixed-latency pipelined backing memory.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | combinational lookup of the current request; hits finish here
// S_EVICT | four write strobes pushing the dirty victim line to memory
// S_FILL  | four read strobes, words land MEM_LAT cycles after each strobe
// S_RESP  | one cycle completing the missed load/store from the new line
module dcache_ctrl #(
    parameter int INDEX_BITS = 5,
    parameter int MEM_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheReq,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] memAddr,
    output logic [15:0] memDataOut,
    output logic        memWr,
    output logic        memRd,
    input  logic [15:0] memDataIn
);

    localparam int         LINES       = 1 << INDEX_BITS;
    localparam int         TAG_BITS    = 13 - INDEX_BITS;
    localparam logic [2:0] LAT_C       = 3'(MEM_LAT);
    localparam logic [2:0] FILL_LAST_C = 3'(MEM_LAT + 3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVICT = 2'd1,
        S_FILL  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
    logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
    logic [1:0]            miss_word_q, miss_word_d;
    logic                  miss_wr_q, miss_wr_d;
    logic [15:0]           miss_data_q, miss_data_d;

    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [15:0]         data_q [LINES][4];

    logic [1:0]            a_word;
    logic [INDEX_BITS-1:0] a_idx;
    logic [TAG_BITS-1:0]   a_tag;
    logic                  req_ok;
    logic                  hit;

    logic                  data_we_c, data_we;
    logic [INDEX_BITS-1:0] data_widx;
    logic [1:0]            data_wword;
    logic [15:0]           data_wdata;
    logic                  tag_we_c, tag_we;

    logic [15:0] dout_c, maddr_c, mdout_c;
    logic        done_c, stall_c, req_c, hit_c, err_c, mwr_c, mrd_c;

    assign a_word = Addr[2:1];
    assign a_idx  = Addr[2+INDEX_BITS:3];
    assign a_tag  = Addr[15:3+INDEX_BITS];
    assign req_ok = (Rd ^ Wr) && !Addr[0];
    assign hit    = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss_idx_d  = miss_idx_q;
        miss_tag_d  = miss_tag_q;
        miss_word_d = miss_word_q;
        miss_wr_d   = miss_wr_q;
        miss_data_d = miss_data_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        data_we_c   = 1'b0;
        data_widx   = miss_idx_q;
        data_wword  = miss_word_q;
        data_wdata  = miss_data_q;
        tag_we_c    = 1'b0;
        dout_c      = 16'h0000;
        maddr_c     = 16'h0000;
        mdout_c     = 16'h0000;
        done_c      = 1'b0;
        stall_c     = 1'b0;
        req_c       = 1'b0;
        hit_c       = 1'b0;
        err_c       = 1'b0;
        mwr_c       = 1'b0;
        mrd_c       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    req_c = 1'b1;
                    if (hit) begin
                        done_c = 1'b1;
                        hit_c  = 1'b1;
                        if (Rd) begin
                            dout_c = data_q[a_idx][a_word];
                        end else begin
                            data_we_c      = 1'b1;
                            data_widx      = a_idx;
                            data_wword     = a_word;
                            data_wdata     = DataIn;
                            dirty_d[a_idx] = 1'b1;
                        end
                    end else begin
                        stall_c     = 1'b1;
                        miss_idx_d  = a_idx;
                        miss_tag_d  = a_tag;
                        miss_word_d = a_word;
                        miss_wr_d   = Wr;
                        miss_data_d = DataIn;
                        cnt_d       = 3'd0;
                        state_d     = (valid_q[a_idx] && dirty_q[a_idx]) ? S_EVICT : S_FILL;
                    end
                end else if (Rd || Wr) begin
                    err_c = 1'b1;
                end
            end

            S_EVICT: begin
                stall_c = 1'b1;
                mwr_c   = 1'b1;
                maddr_c = {tag_q[miss_idx_q], miss_idx_q, cnt_q[1:0], 1'b0};
                mdout_c = data_q[miss_idx_q][cnt_q[1:0]];
                if (cnt_q[1:0] == 2'd3) begin
                    cnt_d   = 3'd0;
                    state_d = S_FILL;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_FILL: begin
                stall_c = 1'b1;
                if (!cnt_q[2]) begin
                    mrd_c   = 1'b1;
                    maddr_c = {miss_tag_q, miss_idx_q, cnt_q[1:0], 1'b0};
                end
                // Word k of the line returns MEM_LAT cycles after its read strobe.
                if (cnt_q >= LAT_C) begin
                    data_we_c  = 1'b1;
                    data_widx  = miss_idx_q;
                    data_wword = 2'(cnt_q - LAT_C);
                    data_wdata = memDataIn;
                end
                if (cnt_q == FILL_LAST_C) begin
                    valid_d[miss_idx_q] = 1'b1;
                    dirty_d[miss_idx_q] = 1'b0;
                    tag_we_c            = 1'b1;
                    cnt_d               = 3'd0;
                    state_d             = S_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_RESP: begin
                done_c = 1'b1;
                if (miss_wr_q) begin
                    data_we_c           = 1'b1;
                    data_widx           = miss_idx_q;
                    data_wword          = miss_word_q;
                    data_wdata          = miss_data_q;
                    dirty_d[miss_idx_q] = 1'b1;
                end else begin
                    dout_c = data_q[miss_idx_q][miss_word_q];
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            miss_idx_q  <= '0;
            miss_tag_q  <= '0;
            miss_word_q <= 2'd0;
            miss_wr_q   <= 1'b0;
            miss_data_q <= 16'h0000;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            miss_idx_q  <= miss_idx_d;
            miss_tag_q  <= miss_tag_d;
            miss_word_q <= miss_word_d;
            miss_wr_q   <= miss_wr_d;
            miss_data_q <= miss_data_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits make them don't-care.
    assign data_we = data_we_c & ~rst;
    assign tag_we  = tag_we_c & ~rst;

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[data_widx][data_wword] <= data_wdata;
        end
        if (tag_we) begin
            tag_q[miss_idx_q] <= miss_tag_q;
        end
    end

    assign DataOut    = rst ? 16'h0000 : dout_c;
    assign memAddr    = rst ? 16'h0000 : maddr_c;
    assign memDataOut = rst ? 16'h0000 : mdout_c;
    assign Done       = done_c & ~rst;
    assign Stall      = stall_c & ~rst;
    assign CacheReq   = req_c & ~rst;
    assign CacheHit   = hit_c & ~rst;
    assign err        = err_c & ~rst;
    assign memWr      = mwr_c & ~rst;
    assign memRd      = mrd_c & ~rst;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a transaction-level cache model predicts every
// cycle's outputs; a pipelined memory model answers reads after MEM_LAT.
module tb_dcache_ctrl;

    localparam int IB = 5;
    localparam int TW = 13 - IB;
    localparam int L  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut, memAddr, memDataOut, memDataIn;
    logic        Rd, Wr, Done, Stall, CacheReq, CacheHit, err, memWr, memRd;

    dcache_ctrl #(.INDEX_BITS(IB), .MEM_LAT(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .Addr       (Addr),
        .DataIn     (DataIn),
        .Rd         (Rd),
        .Wr         (Wr),
        .DataOut    (DataOut),
        .Done       (Done),
        .Stall      (Stall),
        .CacheReq   (CacheReq),
        .CacheHit   (CacheHit),
        .err        (err),
        .memAddr    (memAddr),
        .memDataOut (memDataOut),
        .memWr      (memWr),
        .memRd      (memRd),
        .memDataIn  (memDataIn)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int last_done_cyc = -1;
    logic [15:0] last_done_dout = 16'h0000;

    logic        e_on = 1'b0;
    logic        e_done, e_stall, e_req, e_hit, e_err, e_mwr, e_mrd, e_dout_chk, e_rst;
    logic [15:0] e_maddr, e_mdout, e_dout;

    logic [15:0] mem_model [32768];
    logic        mvalid [1<<IB];
    logic        mdirty [1<<IB];
    logic [TW-1:0] mtag [1<<IB];
    logic [15:0] mdata [1<<IB][4];

    logic        smp_rd = 1'b0;
    logic [15:0] smp_a  = 16'h0000;
    logic        pv [1:L];
    logic [15:0] pa [1:L];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cyc=%0d %s: got %h expected %h", cyc, nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Backing memory: writes land mid-cycle, reads return exactly L cycles later.
    initial forever begin
        @(negedge clk);
        smp_rd = memRd;
        smp_a  = memAddr;
        if (memWr) mem_model[memAddr[15:1]] = memDataOut;
    end

    initial begin
        memDataIn = 16'hDEAD;
        for (int i = 1; i <= L; i++) begin
            pv[i] = 1'b0;
            pa[i] = 16'h0000;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = L; i >= 2; i--) begin
                pv[i] = pv[i-1];
                pa[i] = pa[i-1];
            end
            pv[1] = smp_rd;
            pa[1] = smp_a;
            memDataIn = pv[L] ? mem_model[pa[L][15:1]] : 16'hDEAD;
        end
    end

    initial forever begin
        @(negedge clk);
        if (Done) begin
            last_done_cyc  = cyc;
            last_done_dout = DataOut;
        end
        if (e_on) begin
            chk("Done", {15'd0, Done}, {15'd0, e_done});
            chk("Stall", {15'd0, Stall}, {15'd0, e_stall});
            chk("CacheReq", {15'd0, CacheReq}, {15'd0, e_req});
            chk("CacheHit", {15'd0, CacheHit}, {15'd0, e_hit});
            chk("err", {15'd0, err}, {15'd0, e_err});
            chk("memWr", {15'd0, memWr}, {15'd0, e_mwr});
            chk("memRd", {15'd0, memRd}, {15'd0, e_mrd});
            if (e_mwr || e_mrd || e_rst) chk("memAddr", memAddr, e_maddr);
            if (e_mwr || e_rst) chk("memDataOut", memDataOut, e_mdout);
            if (e_dout_chk) chk("DataOut", DataOut, e_dout);
        end
    end

    task automatic exp_clear();
        e_done = 1'b0; e_stall = 1'b0; e_req = 1'b0; e_hit = 1'b0; e_err = 1'b0;
        e_mwr = 1'b0; e_mrd = 1'b0; e_dout_chk = 1'b0; e_rst = 1'b0;
        e_maddr = 16'h0000; e_mdout = 16'h0000; e_dout = 16'h0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int ncyc);
        rst = 1'b1;
        for (int i = 0; i < (1 << IB); i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
        repeat (ncyc) begin
            exp_clear();
            e_rst = 1'b1;
            e_dout_chk = 1'b1;
            step();
        end
        rst = 1'b0;
        Rd  = 1'b0;
        Wr  = 1'b0;
    endtask

    // One request; abort_at>0 returns after that many cycles of a miss.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input int abort_at);
        logic [IB-1:0] idx;
        logic [TW-1:0] tg;
        logic [1:0]    w;
        logic [15:0]   fillw [4];
        int            n;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        start_cyc = cyc;
        idx = a[2+IB:3];
        tg  = a[15:3+IB];
        w   = a[2:1];
        exp_clear();
        if ((rd && wr) || ((rd || wr) && a[0])) begin
            e_err = 1'b1;
            step();
            return;
        end
        if (!rd && !wr) begin
            step();
            return;
        end
        e_req = 1'b1;
        if (mvalid[idx] && mtag[idx] == tg) begin
            e_hit = 1'b1;
            e_done = 1'b1;
            if (rd) begin
                e_dout_chk = 1'b1;
                e_dout = mdata[idx][w];
            end else begin
                mdata[idx][w] = d;
                mdirty[idx] = 1'b1;
            end
            step();
            return;
        end
        for (int k = 0; k < 4; k++) fillw[k] = mem_model[{tg, idx, 2'(k)}];
        e_stall = 1'b1;
        step();
        n = 1;
        if (mvalid[idx] && mdirty[idx]) begin
            for (int k = 0; k < 4; k++) begin
                if (abort_at > 0 && n >= abort_at) return;
                exp_clear();
                e_stall = 1'b1;
                e_mwr   = 1'b1;
                e_maddr = {mtag[idx], idx, 2'(k), 1'b0};
                e_mdout = mdata[idx][k];
                step();
                n++;
            end
        end
        for (int c = 0; c < 4 + L; c++) begin
            if (abort_at > 0 && n >= abort_at) return;
            exp_clear();
            e_stall = 1'b1;
            if (c < 4) begin
                e_mrd   = 1'b1;
                e_maddr = {tg, idx, 2'(c), 1'b0};
            end
            step();
            n++;
        end
        mvalid[idx] = 1'b1;
        mdirty[idx] = 1'b0;
        mtag[idx]   = tg;
        for (int k = 0; k < 4; k++) mdata[idx][k] = fillw[k];
        exp_clear();
        e_done = 1'b1;
        if (rd) begin
            e_dout_chk = 1'b1;
            e_dout = mdata[idx][w];
        end else begin
            mdata[idx][w] = d;
            mdirty[idx] = 1'b1;
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem_model[i] = 16'(i * 7) ^ 16'hA5C3;
        mem_model[16'h0010 >> 1] = 16'hBEEF;
        exp_clear();
        rst = 1'b1; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010; DataIn = 16'h0000;
        step();
        e_on = 1'b1;
        apply_reset(2);
        do_req(1'b0, 1'b0, 16'h0000, 16'h0000, 0);

        do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 0);
        chk("clean_miss_latency", 16'(last_done_cyc - start_cyc), 16'd7);
        chk("clean_miss_data", last_done_dout, 16'hBEEF);

        do_req(1'b1, 1'b0, 16'h0012, 16'h0000, 0);
        chk("hit_latency", 16'(last_done_cyc - start_cyc), 16'd0);

        do_req(1'b0, 1'b1, 16'h0014, 16'h1234, 0);
        do_req(1'b1, 1'b0, 16'h0110, 16'h0000, 0);
        chk("dirty_miss_latency", 16'(last_done_cyc - start_cyc), 16'd11);
        chk("writeback_0x0014", mem_model[16'h0014 >> 1], 16'h1234);

        do_req(1'b0, 1'b1, 16'h0200, 16'h5A5A, 0);
        chk("store_miss_latency", 16'(last_done_cyc - start_cyc), 16'd7);
        do_req(1'b1, 1'b0, 16'h0200, 16'h0000, 0);
        chk("store_miss_readback", last_done_dout, 16'h5A5A);
        do_req(1'b0, 1'b0, 16'h0000, 16'h0000, 0);

        do_req(1'b1, 1'b1, 16'h0010, 16'h0000, 0);
        do_req(1'b1, 1'b0, 16'h0011, 16'h0000, 0);
        do_req(1'b0, 1'b1, 16'h0013, 16'hFFFF, 0);
        do_req(1'b0, 1'b0, 16'h0000, 16'h0000, 0);

        do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 3);
        apply_reset(2);
        do_req(1'b0, 1'b0, 16'h0000, 16'h0000, 0);
        do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 0);
        chk("post_reset_latency", 16'(last_done_cyc - start_cyc), 16'd7);
        chk("post_reset_data", last_done_dout, 16'hBEEF);
        do_req(1'b1, 1'b0, 16'h0016, 16'h0000, 0);

        do_req(1'b0, 1'b1, 16'h0200, 16'h5A5A, 0);
        do_req(1'b0, 1'b1, 16'h0404, 16'h7777, 0);
        do_req(1'b1, 1'b0, 16'h0200, 16'h0000, 0);
        chk("evict_refill_latency", 16'(last_done_cyc - start_cyc), 16'd11);
        chk("evict_refill_data", last_done_dout, 16'h5A5A);
        chk("writeback_0x0404", mem_model[16'h0404 >> 1], 16'h7777);
        do_req(1'b0, 1'b0, 16'h0000, 16'h0000, 0);

        e_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
